// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin scheduler sharing one pipelined fp_add/round unit; optional FP_ADD_ARB_STATS_EN grant counters
package fp_add_arbiter_pkg;
    typedef enum logic [1:0] {FP32, FP64, FP16, FP16ALT} fp_format_e;

    function automatic int fp_width(fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            FP64:    return 64;
            default: return 16;
        endcase
    endfunction
endpackage

module fp_add_arbiter
    import fp_add_arbiter_pkg::*;
#(
    parameter fp_format_e FP_FORMAT   = FP32,
    parameter int         NUM_REQ     = 4,
    parameter int         FPU_LATENCY = 2,
    localparam int        FP_WIDTH    = fp_width(FP_FORMAT),
    localparam int        ID_W        = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*FP_WIDTH-1:0]   req_a_i,
    input  logic [NUM_REQ*FP_WIDTH-1:0]   req_b_i,
    input  logic [NUM_REQ-1:0]            req_sub_i,
    input  logic [NUM_REQ*3-1:0]          req_rnd_i,
    output logic [FP_WIDTH-1:0]           fpu_a_o,
    output logic [FP_WIDTH-1:0]           fpu_b_o,
    output logic                          fpu_sub_o,
    output logic [2:0]                    fpu_rnd_o,
    output logic [1:0]                    fpu_rs_o,
    output logic                          fpu_start_o,
    input  logic [FP_WIDTH-1:0]           fpu_result_i,
    input  logic [4:0]                    fpu_flags_i,
    output logic [NUM_REQ-1:0]            resp_valid_o,
    output logic [ID_W-1:0]               resp_id_o,
    output logic [FP_WIDTH-1:0]           resp_result_o,
    output logic [4:0]                    resp_flags_o,
    output logic                          busy_o
`ifdef FP_ADD_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]         grant_cnt_o
`endif
);

    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] cand;
    logic [ID_W:0]   sum;
    logic            grant_found;

    // Scan from the rr pointer, wrapping modulo NUM_REQ; first valid wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        sum         = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NUM_REQ))
                sum = sum - (ID_W+1)'(NUM_REQ);
            cand = sum[ID_W-1:0];
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    assign req_ready_o = (grant_found && !rst_i) ? (ONE << grant_id) : '0;
    assign fpu_start_o = |req_ready_o;
    assign fpu_a_o     = fpu_start_o ? req_a_i[grant_id*FP_WIDTH +: FP_WIDTH] : '0;
    assign fpu_b_o     = fpu_start_o ? req_b_i[grant_id*FP_WIDTH +: FP_WIDTH] : '0;
    assign fpu_sub_o   = fpu_start_o ? req_sub_i[grant_id] : 1'b0;
    assign fpu_rnd_o   = fpu_start_o ? req_rnd_i[grant_id*3 +: 3] : 3'b000;
    assign fpu_rs_o    = 2'b00;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            rr_ptr <= '0;
        else if (fpu_start_o)
            rr_ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
    end

    logic            cap_valid;
    logic [ID_W-1:0] cap_id;
    logic            pipe_busy;

    generate
        if (FPU_LATENCY == 0) begin : g_lat0
            assign cap_valid = fpu_start_o;
            assign cap_id    = grant_id;
            assign pipe_busy = 1'b0;
        end else begin : g_pipe
            logic [FPU_LATENCY-1:0] tag_valid;
            logic [ID_W-1:0]        tag_id [FPU_LATENCY];

            // Only the valid bits need reset; ids are ignored while their valid is low.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    tag_valid <= '0;
                end else begin
                    tag_valid[0] <= fpu_start_o;
                    for (int i = 1; i < FPU_LATENCY; i++)
                        tag_valid[i] <= tag_valid[i-1];
                end
                tag_id[0] <= grant_id;
                for (int i = 1; i < FPU_LATENCY; i++)
                    tag_id[i] <= tag_id[i-1];
            end

            assign cap_valid = tag_valid[FPU_LATENCY-1];
            assign cap_id    = tag_id[FPU_LATENCY-1];
            assign pipe_busy = |tag_valid;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_o  <= '0;
            resp_id_o     <= '0;
            resp_result_o <= '0;
            resp_flags_o  <= '0;
        end else begin
            resp_valid_o <= cap_valid ? (ONE << cap_id) : '0;
            if (cap_valid) begin
                resp_id_o     <= cap_id;
                resp_result_o <= fpu_result_i;
                resp_flags_o  <= fpu_flags_i;
            end
        end
    end

    assign busy_o = pipe_busy | (|resp_valid_o) | fpu_start_o;

`ifdef FP_ADD_ARB_STATS_EN
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst_i)
                grant_cnt_o[i*16 +: 16] <= '0;
            else if (req_valid_i[i] && req_ready_o[i] && grant_cnt_o[i*16 +: 16] != 16'hFFFF)
                grant_cnt_o[i*16 +: 16] <= grant_cnt_o[i*16 +: 16] + 16'd1;
        end
    end
`endif

endmodule
